// File: rtl/hni_txdat_arb_if.sv
// Requester-side and TXDAT link signals of hni_txdat_arb.
// master: the arbiter; slave: requesters plus the XP link partner.
`ifndef CHIE_DAT_FLIT_WIDTH
`define CHIE_DAT_FLIT_WIDTH 256
`endif

interface hni_txdat_arb_if #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned DAT_FLIT_WIDTH = `CHIE_DAT_FLIT_WIDTH
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ*DAT_FLIT_WIDTH-1:0] req_flit;
    logic [NUM_REQ-1:0]                req_ready;
    logic                              txdat_lcrdv;
    logic                              txdatflitpend;
    logic                              txdatflitv;
    logic [DAT_FLIT_WIDTH-1:0]         txdatflit;

    modport master (
        input  req_valid, req_flit, txdat_lcrdv,
        output req_ready, txdatflitpend, txdatflitv, txdatflit
    );

    modport slave (
        output req_valid, req_flit, txdat_lcrdv,
        input  req_ready, txdatflitpend, txdatflitv, txdatflit
    );
endinterface

// File: rtl/hni_txdat_arb.sv
// HNI TXDAT arbiter: muxes NUM_REQ data sources onto TXDAT and owns the TX link credits.
// Define HNI_TXDAT_ARB_FIXPRI_EN for fixed priority (lowest index wins) instead of round-robin.
`ifndef CHIE_DAT_FLIT_WIDTH
`define CHIE_DAT_FLIT_WIDTH 256
`endif

module hni_txdat_arb #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned CRD_MAX        = 15,
    parameter int unsigned CRD_CNT_WIDTH  = 4,
    parameter int unsigned DAT_FLIT_WIDTH = `CHIE_DAT_FLIT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     link_deact_req,
    output logic                     link_deact_done,
    output logic [CRD_CNT_WIDTH-1:0] txdat_crd_cnt,
    output logic                     txdat_crd_ovf,
    hni_txdat_arb_if.master          bus
);

    typedef enum logic [1:0] {StRun, StReturn, StStop} state_e;

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CRD_CNT_WIDTH-1:0] CrdMax = CRD_CNT_WIDTH'(CRD_MAX);

    state_e                    state_q, state_d;
    logic [CRD_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic                      done_q;
    logic                      flitv_q;
    logic [DAT_FLIT_WIDTH-1:0] flit_q, flit_d;
    logic [NUM_REQ-1:0]        grant;
    logic [PtrW-1:0]           win;
    logic                      found;
    logic                      crd_avail;
    logic                      send;

`ifndef HNI_TXDAT_ARB_FIXPRI_EN
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);
    logic [PtrW-1:0] ptr_q, ptr_d;
`endif

    assign crd_avail = (cnt_q != '0);

    // First valid requester, searching upward from the pointer (or from 0 in fixed priority).
    always_comb begin
        logic [PtrW-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef HNI_TXDAT_ARB_FIXPRI_EN
            idx = PtrW'(i);
`else
            idx = PtrW'((32'(ptr_q) + i) % NUM_REQ);
`endif
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // A credit arriving this cycle is not spendable until the next one.
    always_comb begin
        grant  = '0;
        send   = 1'b0;
        flit_d = '0;
        unique case (state_q)
            StRun: begin
                if (crd_avail && found) begin
                    grant[win] = 1'b1;
                    send       = 1'b1;
                end
            end
            StReturn: send = crd_avail;  // all-zero flit is a DataLCrdReturn
            default: ;
        endcase
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                flit_d = flit_d | bus.req_flit[i*DAT_FLIT_WIDTH +: DAT_FLIT_WIDTH];
            end
        end
    end

`ifndef HNI_TXDAT_ARB_FIXPRI_EN
    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == StRun) && send) begin
            ptr_d = (win == LastIdx) ? '0 : win + 1'b1;
        end
    end
`endif

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (bus.txdat_lcrdv && !send) begin
            if (cnt_q == CrdMax) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!bus.txdat_lcrdv && send) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (link_deact_req) state_d = StReturn;
            end
            StReturn: begin
                if (!link_deact_req) begin
                    state_d = StRun;
                end else if (!crd_avail && !bus.txdat_lcrdv) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (!link_deact_req) begin
                    state_d = StRun;
                end else if (bus.txdat_lcrdv) begin
                    state_d = StReturn;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            flitv_q <= 1'b0;
            flit_q  <= '0;
`ifndef HNI_TXDAT_ARB_FIXPRI_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= (state_d == StStop);
            flitv_q <= send;
            flit_q  <= flit_d;
`ifndef HNI_TXDAT_ARB_FIXPRI_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.req_ready     = grant;
    assign bus.txdatflitpend = send;
    assign bus.txdatflitv    = flitv_q;
    assign bus.txdatflit     = flit_q;
    assign link_deact_done   = done_q;
    assign txdat_crd_cnt     = cnt_q;
    assign txdat_crd_ovf     = ovf_q;

endmodule

// File: tb/tb_hni_txdat_arb.sv
// Self-checking bench for hni_txdat_arb: directed vector table, hand-written corner sequences,
// then random traffic against a cycle-level credit/arbitration reference model.
module tb_hni_txdat_arb;
    localparam int N       = 2;
    localparam int W       = 64;
    localparam int CRD_MAX = 15;
    localparam int MRUN    = 0;
    localparam int MRET    = 1;
    localparam int MSTOP   = 2;
    localparam logic [W-1:0] F0 = 64'h0000_00A0_A0A0_A0A0;
    localparam logic [W-1:0] F1 = 64'h0000_00B1_B1B1_B1B1;

    logic       clk;
    logic       rst;
    logic       link_deact_req;
    logic       link_deact_done;
    logic [3:0] txdat_crd_cnt;
    logic       txdat_crd_ovf;

    hni_txdat_arb_if #(.NUM_REQ(N), .DAT_FLIT_WIDTH(W)) bus ();

    hni_txdat_arb #(
        .NUM_REQ(N), .CRD_MAX(CRD_MAX), .CRD_CNT_WIDTH(4), .DAT_FLIT_WIDTH(W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .link_deact_req  (link_deact_req),
        .link_deact_done (link_deact_done),
        .txdat_crd_cnt   (txdat_crd_cnt),
        .txdat_crd_ovf   (txdat_crd_ovf),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int           m_cnt, m_mode, m_ptr;
    bit           m_ovf, m_fv, m_done;
    logic [W-1:0] m_flit;

    typedef struct {
        logic         lcrdv;
        logic [1:0]   valid;
        logic [1:0]   ready;
        logic         pend;
        logic         flitv;
        logic [W-1:0] flit;
        int           cnt;
    } vec_t;
    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_mode = MRUN; m_ptr = 0;
        m_ovf = 0; m_fv = 0; m_done = 0; m_flit = '0;
    endtask

    task automatic model_eval(output logic [N-1:0] rdy, output bit send,
                              output logic [W-1:0] sflit, output int win);
        rdy = '0; send = 0; sflit = '0; win = -1;
        if (m_mode == MRUN && m_cnt > 0) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && bus.req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            if (win >= 0) begin
                rdy[win] = 1'b1;
                send     = 1;
                sflit    = bus.req_flit[win*W +: W];
            end
        end else if (m_mode == MRET && m_cnt > 0) begin
            send = 1;
        end
    endtask

    task automatic model_step(input bit send, input logic [W-1:0] sflit, input int win);
        bit lc;
        int old_cnt;
        lc      = bus.txdat_lcrdv;
        old_cnt = m_cnt;
        m_fv    = send;
        m_flit  = sflit;
        if (send && m_mode == MRUN) m_ptr = (win + 1) % N;
        if (lc && !send) begin
            if (m_cnt == CRD_MAX) m_ovf = 1;
            else m_cnt++;
        end else if (!lc && send) begin
            m_cnt--;
        end
        case (m_mode)
            MRUN:  if (link_deact_req) m_mode = MRET;
            MRET:  if (!link_deact_req) m_mode = MRUN;
                   else if (old_cnt == 0 && !lc) m_mode = MSTOP;
            default: if (!link_deact_req) m_mode = MRUN;
                     else if (lc) m_mode = MRET;
        endcase
        m_done = (m_mode == MSTOP);
    endtask

    // Inputs are already driven; sample mid-cycle, compare, advance the model.
    task automatic cycle();
        logic [N-1:0] er;
        bit           es;
        logic [W-1:0] ef;
        int           win;
        @(negedge clk);
        model_eval(er, es, ef, win);
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("flitpend", 64'(bus.txdatflitpend), 64'(es));
        chk("flitv", 64'(bus.txdatflitv), 64'(m_fv));
        chk("flit", bus.txdatflit, m_flit);
        chk("crd_cnt", 64'(txdat_crd_cnt), 64'(m_cnt));
        chk("crd_ovf", 64'(txdat_crd_ovf), 64'(m_ovf));
        chk("deact_done", 64'(link_deact_done), 64'(m_done));
        model_step(es, ef, win);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lc, input logic [1:0] v);
        bus.txdat_lcrdv = lc;
        bus.req_valid   = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nflits, npend;
        logic [N-1:0] er;
        bit           es;
        logic [W-1:0] ef;
        int           win;

        // lcrdv, valid, ready, pend, flitv, flit, cnt (registered count seen that cycle)
        vecs[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, '0, 0};
        vecs[1]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, '0, 1};
        vecs[2]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, '0, 2};
        vecs[3]  = '{1'b0, 2'b11, 2'b01, 1'b1, 1'b0, '0, 3};
        vecs[4]  = '{1'b0, 2'b11, 2'b10, 1'b1, 1'b1, F0, 2};
        vecs[5]  = '{1'b0, 2'b11, 2'b01, 1'b1, 1'b1, F1, 1};
        vecs[6]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, F0, 0};
        vecs[7]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b0, '0, 0};
        vecs[8]  = '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, '0, 0};
        vecs[9]  = '{1'b0, 2'b11, 2'b10, 1'b1, 1'b0, '0, 1};
        vecs[10] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, F1, 0};
        vecs[11] = '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, '0, 0};
        vecs[12] = '{1'b1, 2'b11, 2'b01, 1'b1, 1'b0, '0, 1};
        vecs[13] = '{1'b0, 2'b11, 2'b10, 1'b1, 1'b1, F0, 1};
        vecs[14] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, F1, 0};
        vecs[15] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, '0, 0};

        link_deact_req = 1'b0;
        bus.req_flit   = {F1, F0};
        do_reset();

        // Reset state
        chk("rst_cnt", 64'(txdat_crd_cnt), 64'd0);
        chk("rst_flitv", 64'(bus.txdatflitv), 64'd0);
        chk("rst_done", 64'(link_deact_done), 64'd0);
        chk("rst_ovf", 64'(txdat_crd_ovf), 64'd0);

        // Directed table: RR alternation, credit latency, lcrdv+grant same cycle
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].lcrdv, vecs[i].valid);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 64'(bus.req_ready), 64'(vecs[i].ready));
            chk($sformatf("vec%0d_pend", i), 64'(bus.txdatflitpend), 64'(vecs[i].pend));
            chk($sformatf("vec%0d_flitv", i), 64'(bus.txdatflitv), 64'(vecs[i].flitv));
            chk($sformatf("vec%0d_flit", i), bus.txdatflit, vecs[i].flit);
            chk($sformatf("vec%0d_cnt", i), 64'(txdat_crd_cnt), 64'(vecs[i].cnt));
            model_eval(er, es, ef, win);
            model_step(es, ef, win);
            @(posedge clk);
            #1;
        end

        // Saturation: 16 credits with nothing to send, overflow stays sticky
        drive(1'b1, 2'b00);
        repeat (16) cycle();
        drive(1'b0, 2'b00);
        repeat (100) cycle();
        chk("sat_cnt", 64'(txdat_crd_cnt), 64'd15);
        chk("ovf_sticky", 64'(txdat_crd_ovf), 64'd1);

        // Deactivation with 4 credits held
        do_reset();
        drive(1'b1, 2'b00);
        repeat (4) cycle();
        drive(1'b0, 2'b00);
        cycle();
        link_deact_req = 1'b1;
        cycle();
        drive(1'b0, 2'b11);
        nflits = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (bus.txdatflitv && bus.txdatflit == '0) nflits++;
        end
        chk("deact_ret_flits", 64'(nflits), 64'd4);
        chk("deact_cnt", 64'(txdat_crd_cnt), 64'd0);
        chk("deact_done_hi", 64'(link_deact_done), 64'd1);

        // Credit arriving in STOP is returned once
        drive(1'b1, 2'b11);
        cycle();
        drive(1'b0, 2'b11);
        nflits = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (bus.txdatflitv) nflits++;
        end
        chk("stop_ret_flits", 64'(nflits), 64'd1);
        chk("stop_done_again", 64'(link_deact_done), 64'd1);

        // Reactivate; grants resume
        link_deact_req = 1'b0;
        cycle();
        chk("react_done_lo", 64'(link_deact_done), 64'd0);
        drive(1'b1, 2'b11);
        cycle();
        drive(1'b0, 2'b11);
        npend = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.txdatflitpend) npend++;
            cycle();
        end
        chk("react_grants", 64'(npend), 64'd1);

        // Asynchronous reset with credits held and a flit in flight
        do_reset();
        drive(1'b1, 2'b00);
        repeat (5) cycle();
        drive(1'b0, 2'b11);
        cycle();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_cnt", 64'(txdat_crd_cnt), 64'd0);
        chk("arst_flitv", 64'(bus.txdatflitv), 64'd0);
        chk("arst_flit", bus.txdatflit, 64'd0);
        chk("arst_pend", 64'(bus.txdatflitpend), 64'd0);
        chk("arst_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle();
        chk("post_rst_flitv", 64'(bus.txdatflitv), 64'd0);

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            bus.txdat_lcrdv = ($urandom_range(0, 9) < 4);
            bus.req_valid   = 2'($urandom_range(0, 3));
            bus.req_flit    = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 39) == 0) link_deact_req = ~link_deact_req;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
